// File: rtl/seq_detector_n.sv
// Parametrised serial pattern detector (MSB first) with selectable overlap,
// visible matched-prefix state and a saturating detection counter.
module seq_detector_n #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     x,
    input  logic                     en,
    input  logic                     clr,
    output logic [$clog2(PAT_W)-1:0] state,
    output logic                     detect,
    output logic [CNT_W-1:0]         match_count,
    output logic                     count_sat
);

    localparam int ST_W = $clog2(PAT_W);
    localparam int TBL  = 2 ** (ST_W + 1);

    // Longest k <= maxk such that the last k bits of (first l pattern bits, b)
    // equal the first k pattern bits. Evaluated only at elaboration.
    function automatic int longest(input int l, input int b, input int maxk);
        logic [PAT_W:0] s;
        int             best;
        bit             ok;
        s    = '0;
        best = 0;
        if (l >= PAT_W) return 0;
        for (int i = 0; i < l; i++) s[i] = PATTERN[PAT_W-1-i];
        s[l] = b[0];
        for (int k = 1; k <= maxk; k++) begin
            ok = 1'b1;
            for (int j = 0; j < k; j++)
                if (s[l+1-k+j] != PATTERN[PAT_W-1-j]) ok = 1'b0;
            if (ok) best = k;
        end
        return best;
    endfunction

    // Restart point after a full match: longest proper suffix that is a prefix.
    localparam int FAIL_LEN = longest(PAT_W - 1, int'(PATTERN[0]), PAT_W - 1);

    logic [ST_W-1:0] nxt_tbl [TBL];
    logic            hit_tbl [TBL];

    for (genvar l = 0; l < 2 ** ST_W; l++) begin : g_len
        for (genvar b = 0; b < 2; b++) begin : g_bit
            localparam int K   = longest(l, b, l + 1);
            localparam int NXT = (K == PAT_W) ? (OVERLAP ? FAIL_LEN : 0) : K;
            assign nxt_tbl[l*2+b] = ST_W'(NXT);
            assign hit_tbl[l*2+b] = (K == PAT_W);
        end
    end

    logic [ST_W-1:0]  len_q, len_d;
    logic             det_q, det_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q <= '0;
            det_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            len_q <= len_d;
            det_q <= det_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        len_d = len_q;
        det_d = 1'b0;
        cnt_d = cnt_q;
        if (en) begin
            len_d = nxt_tbl[{len_q, x}];
            det_d = hit_tbl[{len_q, x}];
        end
        // A clear on the same edge as a detection wins over the increment.
        if (clr)
            cnt_d = '0;
        else if (det_d && !(&cnt_q))
            cnt_d = cnt_q + 1'b1;
    end

    assign state       = len_q;
    assign detect      = det_q;
    assign match_count = cnt_q;
    assign count_sat   = &cnt_q;

endmodule

// File: tb/tb_seq_detector_n.sv
// Directed bench for seq_detector_n: overlap, non-overlap and saturating
// variants share one stimulus stream; each check looks at the relevant copy.
module tb_seq_detector_n;

    logic clk = 1'b0;
    logic reset, x, en, clr;

    logic [1:0] ov_state, nov_state, sat_state;
    logic       ov_det, nov_det, sat_det;
    logic [7:0] ov_cnt, nov_cnt;
    logic [1:0] sat_cnt;
    logic       ov_sat, nov_sat, sat_sat;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_detector_n #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
        .clk(clk), .reset(reset), .x(x), .en(en), .clr(clr),
        .state(ov_state), .detect(ov_det), .match_count(ov_cnt), .count_sat(ov_sat)
    );

    seq_detector_n #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_nov (
        .clk(clk), .reset(reset), .x(x), .en(en), .clr(clr),
        .state(nov_state), .detect(nov_det), .match_count(nov_cnt), .count_sat(nov_sat)
    );

    seq_detector_n #(.PAT_W(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .x(x), .en(en), .clr(clr),
        .state(sat_state), .detect(sat_det), .match_count(sat_cnt), .count_sat(sat_sat)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        en    = 1'b0;
        x     = 1'b0;
        clr   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send(input logic b);
        @(negedge clk);
        x  = b;
        en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic b);
        @(negedge clk);
        x  = b;
        en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic [6:0] s1011011 = 7'b1011011;
    logic [5:0] s101011  = 6'b101011;
    int         fb_state [6] = '{1, 2, 3, 2, 3, 1};
    int         sat_cnt_exp [8] = '{0, 0, 0, 1, 2, 3, 3, 3};

    initial begin
        do_reset();
        check("rst_state", 32'(ov_state), 0);
        check("rst_detect", 32'(ov_det), 0);
        check("rst_count", 32'(ov_cnt), 0);
        check("rst_sat", 32'(ov_sat), 0);

        // 1011011: overlap detects twice, non-overlap once
        for (int i = 6; i >= 0; i--) begin
            send(s1011011[i]);
            if (i == 3) begin
                check("ov_det_b4", 32'(ov_det), 1);
                check("ov_state_b4", 32'(ov_state), 1);
                check("nov_det_b4", 32'(nov_det), 1);
                check("nov_state_b4", 32'(nov_state), 0);
            end
            if (i == 2) check("ov_det_b5", 32'(ov_det), 0);
        end
        check("ov_det_b7", 32'(ov_det), 1);
        check("ov_state_b7", 32'(ov_state), 1);
        check("ov_count", 32'(ov_cnt), 2);
        check("nov_det_b7", 32'(nov_det), 0);
        check("nov_state_b7", 32'(nov_state), 1);
        check("nov_count", 32'(nov_cnt), 1);

        // 101011: mismatch fallback from 3 to 2, then completion
        do_reset();
        for (int i = 5; i >= 0; i--) begin
            send(s101011[i]);
            check($sformatf("fb_state_%0d", 6 - i), 32'(ov_state), 32'(fb_state[5-i]));
            if (i == 1) check("fb_det_b5", 32'(ov_det), 0);
        end
        check("fb_det_b6", 32'(ov_det), 1);
        check("fb_count", 32'(ov_cnt), 1);

        // enable hold, then asynchronous reset mid-sequence
        do_reset();
        send(1'b1); send(1'b0); send(1'b1); send(1'b1);
        send(1'b0); send(1'b1);
        check("en_pre_state", 32'(ov_state), 3);
        check("en_pre_count", 32'(ov_cnt), 1);
        idle(1'b0); idle(1'b1); idle(1'bx);
        check("en_hold_state", 32'(ov_state), 3);
        check("en_hold_det", 32'(ov_det), 0);
        check("en_hold_count", 32'(ov_cnt), 1);
        @(negedge clk);
        x  = 1'b1;
        en = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("async_rst_state", 32'(ov_state), 0);
        check("async_rst_count", 32'(ov_cnt), 0);
        @(posedge clk);
        #1;
        check("rst_edge_nosample", 32'(ov_state), 0);
        @(negedge clk);
        reset = 1'b0;
        en    = 1'b0;
        send(1'b1);
        check("post_rst_state", 32'(ov_state), 1);

        // 1111 with a 2-bit counter: back-to-back detects, saturation, clr priority
        do_reset();
        check("sat_rst", 32'(sat_sat), 0);
        for (int i = 0; i < 8; i++) begin
            send(1'b1);
            check($sformatf("sat_det_%0d", i + 1), 32'(sat_det), (i >= 3) ? 1 : 0);
            check($sformatf("sat_cnt_%0d", i + 1), 32'(sat_cnt), 32'(sat_cnt_exp[i]));
        end
        check("sat_flag", 32'(sat_sat), 1);
        @(negedge clk);
        x   = 1'b1;
        en  = 1'b1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        check("clr_det", 32'(sat_det), 1);
        check("clr_count", 32'(sat_cnt), 0);
        check("clr_sat", 32'(sat_sat), 0);
        check("clr_state", 32'(sat_state), 3);
        @(negedge clk);
        clr = 1'b0;
        en  = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_detector_n.md
Name: seq_detector_n

Overview:
- Parametrised serial sequence detector: the next generation of the team's 2-bit Mealy/Moore lab FSM with input x, state outputs and clk/reset.
- Recognises an arbitrary PAT_W-bit pattern on a 1-bit serial input, MSB first.
- Overlap or non-overlap mode is selectable; progress is exposed as visible state, and detections are counted.
- Used as the building block for serial-protocol framing exercises.

Parameters:
- PAT_W, 4, pattern length in bits; legal range 2..16.
- PATTERN, 4'b1011, target pattern, PAT_W bits wide; PATTERN[PAT_W-1] is the first bit expected.
- OVERLAP, 1, 1 = overlapping detection (fallback via failure function); 0 = restart from empty after each match.
- CNT_W, 8, width of the saturating match counter.

Ports:
- clk  input  1  system clock, rising edge active.
- reset  input  1  asynchronous, active-high reset.
- x  input  1  serial data bit, sampled on rising clk when en=1.
- en  input  1  sample enable; when 0, x is ignored.
- clr  input  1  synchronous clear of match_count only.
- state  output  ST_W  matched-prefix length, 0..PAT_W-1, where ST_W = clog2(PAT_W).
- detect  output  1  registered one-cycle pulse on pattern completion.
- match_count  output  CNT_W  number of detections, saturating.
- count_sat  output  1  high while match_count == all ones.

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately, including mid-sequence):
  - state=0, detect=0, match_count=0, count_sat=0.
  - Release is synchronous to the next rising edge; no x is sampled on the edge where reset is still high.
- Internal state is len, the number of pattern bits currently matched (0..PAT_W-1). The FSM has PAT_W states S0..S(PAT_W-1), and the state output equals len.
- Transition on rising clk with en=1:
  - If x == PATTERN[PAT_W-1-len] and len+1 < PAT_W: len <= len+1; detect <= 0.
  - If x == PATTERN[PAT_W-1-len] and len+1 == PAT_W: full match; detect <= 1.
    - If OVERLAP=1, len <= F(PAT_W), the length of the longest proper suffix of PATTERN that is also a prefix.
    - If OVERLAP=0, len <= 0.
  - Mismatch: len <= the longest k < len+1 such that the last k bits of (matched prefix, x) equal the first k bits of PATTERN. It may be 0.
  - The fallback table is computed at elaboration time (constant function or generate). No runtime search.
- With en=0: len holds, detect <= 0, match_count holds.
- detect:
  - High for exactly one clk cycle, beginning at the edge that sampled the final pattern bit.
  - Latency is 0 cycles after that edge; detect is registered, never combinational from x.
- match_count:
  - Increments by 1 on each edge where detect is being set to 1.
  - Saturates at 2^CNT_W-1 with no wrap. count_sat follows combinationally from match_count.
- clr and a detection on the same edge: clr wins; match_count <= 0. detect still pulses and the FSM still advances normally.
- clr affects only match_count; state and detect are unaffected.
- Back-to-back matches in overlap mode: detect may be high on consecutive cycles only if F(PAT_W) == PAT_W-1 (e.g. pattern 1111). Each one counts.
- X on x while en=0 must not propagate to state.

Test Plan:
- Overlap, default PATTERN 1011:
  - Reset, then x=1,0,1,1,0,1,1 with en=1.
  - Required: detect high after bits 4 and 7; match_count=2; state after bit 4 =1 and after bit 7 =1.
- Non-overlap (OVERLAP=0), same stream 1011011:
  - Required: detect after bit 4 only; match_count=1; state after bit 4 =0 and after bit 7 =1.
- Fallback, overlap, stream 1,0,1,0,1,1:
  - Required: state sequence 1,2,3,2,3,0→detect. The final edge gives len=F(4)=1, so state=1; detect after bit 6; match_count=1.
- Enable and reset mid-operation:
  - Feed 1,0,1, drop en for 3 cycles with x toggling: state holds at 3, detect=0.
  - Assert reset asynchronously between edges: state=0 and match_count=0 immediately.
  - Release reset, feed 1: state=1.
- Saturation and clr, CNT_W=2, pattern 1111, overlap:
  - Feed eight 1s. Required: detect on bits 4..8; match_count sticks at 3; count_sat=1.
  - Assert clr coincident with a detect: match_count=0, detect=1 that cycle.
